// File: rtl/asic_iopoc_pkg.sv
// rtl/asic_iopoc_pkg.sv - state encoding and shared constants for the pad-ring power-on controller
package asic_iopoc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_ON      = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/asic_iopoc_sync.sv
// rtl/asic_iopoc_sync.sv - SYNC-deep synchronizer for an asynchronous supply-good input
module asic_iopoc_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] ff;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ff <= '0;
    else         ff <= {ff[SYNC-2:0], d};
  end

  assign q = ff[SYNC-1];

endmodule

// File: rtl/asic_iopoc.sv
// rtl/asic_iopoc.sv - pad-ring power-on controller (POC hold, settle, staggered io_en)
// Optional supply watchdog and FAULT state: define ASIC_IOPOC_WATCHDOG_EN.
module asic_iopoc
  import asic_iopoc_pkg::*;
#(
  parameter int SETTLE  = 1024,
  parameter int STAGGER = 16,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               enable,
  input  logic               vdd_ok,
  input  logic               vddio_ok,
  output logic               poc,
  output logic               io_en,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = $clog2(max3(SETTLE, STAGGER, TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);

  logic             vdd_s, vddio_s, ok;
  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  asic_iopoc_sync #(.SYNC(SYNC)) u_sync_vdd   (.clk(clk), .nreset(nreset), .d(vdd_ok),   .q(vdd_s));
  asic_iopoc_sync #(.SYNC(SYNC)) u_sync_vddio (.clk(clk), .nreset(nreset), .d(vddio_ok), .q(vddio_s));

  assign ok = vdd_s & vddio_s;

  // A dropped supply is checked before the terminal count, so a glitch can only restart SETTLE.
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    if (!enable) begin
      nxt     = ST_OFF;
      cnt_nxt = '0;
    end else begin
      case (cur)
        ST_OFF: begin
          nxt     = ST_WAIT;
          cnt_nxt = '0;
        end
        ST_WAIT: begin
          if (ok) begin
            nxt     = ST_SETTLE;
            cnt_nxt = '0;
          end
`ifdef ASIC_IOPOC_WATCHDOG_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            nxt     = ST_FAULT;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`endif
        end
        ST_SETTLE: begin
          if (!ok) begin
            nxt     = ST_WAIT;
            cnt_nxt = '0;
          end else if (cnt == SETTLE_LAST) begin
            nxt     = ST_RELEASE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!ok) begin
            nxt     = ST_WAIT;
            cnt_nxt = '0;
          end else if (cnt == STAGGER_LAST) begin
            nxt     = ST_ON;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_ON: begin
          if (!ok) begin
            nxt     = ST_WAIT;
            cnt_nxt = '0;
          end
        end
`ifdef ASIC_IOPOC_WATCHDOG_EN
        ST_FAULT: nxt = ST_FAULT;
`endif
        default: begin
          nxt     = ST_OFF;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cur   <= ST_OFF;
      cnt   <= '0;
      poc   <= 1'b1;
      io_en <= 1'b0;
      ready <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_nxt;
      poc   <= (nxt == ST_OFF) || (nxt == ST_WAIT) || (nxt == ST_SETTLE) || (nxt == ST_FAULT);
      io_en <= (nxt == ST_ON);
      ready <= (nxt == ST_ON);
    end
  end

`ifdef ASIC_IOPOC_WATCHDOG_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) fault <= 1'b0;
    else         fault <= (nxt == ST_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

  assign state = cur;

endmodule

// File: tb/tb_asic_iopoc.sv
// tb/tb_asic_iopoc.sv - self-checking bench for asic_iopoc (SETTLE=8, STAGGER=4, SYNC=2, TIMEOUT=32)
module tb_asic_iopoc;
  import asic_iopoc_pkg::*;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       enable = 1'b1;
  logic       vdd_ok = 1'b1;
  logic       vddio_ok = 1'b1;
  logic       poc, io_en, ready, fault;
  logic [2:0] state;

  always #5 clk = ~clk;

  asic_iopoc #(.SETTLE(8), .STAGGER(4), .SYNC(2), .TIMEOUT(32)) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .vdd_ok(vdd_ok), .vddio_ok(vddio_ok),
    .poc(poc), .io_en(io_en), .ready(ready), .fault(fault), .state(state)
  );

  typedef struct {
    logic [2:0] st;
    logic       poc, io_en, ready, fault;
  } exp_t;

  typedef struct {
    logic       en, vdd, vddio;
    logic [2:0] st;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t decode(input logic [2:0] st);
    exp_t e;
    e.st    = st;
    e.poc   = (st == 3'd0) || (st == 3'd1) || (st == 3'd2) || (st == 3'd5);
    e.io_en = (st == 3'd4);
    e.ready = (st == 3'd4);
    e.fault = (st == 3'd5);
    return e;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Called at a falling edge: drive, queue the expectation, compare after the next rising edge.
  task automatic step(input logic en, input logic vdd, input logic vddio,
                      input logic [2:0] st, input string tag);
    exp_t e;
    enable   = en;
    vdd_ok   = vdd;
    vddio_ok = vddio;
    sb.push_back(decode(st));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".state"}, state, e.st);
    check({tag, ".poc"},   3'(poc),   3'(e.poc));
    check({tag, ".io_en"}, 3'(io_en), 3'(e.io_en));
    check({tag, ".ready"}, 3'(ready), 3'(e.ready));
    check({tag, ".fault"}, 3'(fault), 3'(e.fault));
    @(negedge clk);
  endtask

  task automatic from_settle(input string tag);
    for (int i = 0; i < 7; i++) step(1, 1, 1, ST_SETTLE, tag);
    step(1, 1, 1, ST_RELEASE, tag);
    for (int i = 0; i < 3; i++) step(1, 1, 1, ST_RELEASE, tag);
    step(1, 1, 1, ST_ON, tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].en    = 1'b1;
      vecs[i].vdd   = 1'b1;
      vecs[i].vddio = 1'b1;
      vecs[i].st    = (i < 2) ? ST_WAIT : (i < 10) ? ST_SETTLE : (i < 14) ? ST_RELEASE : ST_ON;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst.state", state, 3'd0);
    check("rst.poc",   3'(poc),   3'd1);
    check("rst.io_en", 3'(io_en), 3'd0);
    check("rst.ready", 3'(ready), 3'd0);
    check("rst.fault", 3'(fault), 3'd0);

    // Power-up: reset released with enable and both supplies already high.
    @(negedge clk);
    nreset = 1'b1;
    foreach (vecs[i]) step(vecs[i].en, vecs[i].vdd, vecs[i].vddio, vecs[i].st, "pwrup");

    // One-cycle vddio glitch at SETTLE count 5 must restart a full SETTLE.
    step(0, 1, 1, ST_OFF, "glitch");
    step(1, 1, 1, ST_WAIT, "glitch");
    step(1, 1, 1, ST_SETTLE, "glitch");
    for (int i = 0; i < 5; i++) step(1, 1, 1, ST_SETTLE, "glitch");
    step(1, 1, 0, ST_SETTLE, "glitch");
    step(1, 1, 1, ST_SETTLE, "glitch");
    step(1, 1, 1, ST_WAIT, "glitch");
    step(1, 1, 1, ST_SETTLE, "glitch");
    from_settle("glitch");

    // vdd drop in ON: WAIT with poc high on the third edge.
    step(1, 0, 1, ST_ON, "vdd_drop");
    step(1, 0, 1, ST_ON, "vdd_drop");
    step(1, 0, 1, ST_WAIT, "vdd_drop");
    step(1, 1, 1, ST_WAIT, "recover");
    step(1, 1, 1, ST_WAIT, "recover");
    step(1, 1, 1, ST_SETTLE, "recover");
    for (int i = 0; i < 7; i++) step(1, 1, 1, ST_SETTLE, "recover");
    step(1, 1, 1, ST_RELEASE, "recover");

    // enable low and supplies lost together in RELEASE: enable wins.
    step(0, 0, 0, ST_OFF, "rel_off");

    step(1, 0, 0, ST_WAIT, "wdog");
`ifdef ASIC_IOPOC_WATCHDOG_EN
    for (int i = 0; i < 31; i++) step(1, 0, 0, ST_WAIT, "wdog");
    step(1, 0, 0, ST_FAULT, "wdog");
    for (int i = 0; i < 3; i++) step(1, 1, 1, ST_FAULT, "wdog_hold");
`else
    for (int i = 0; i < 100; i++) step(1, 0, 0, ST_WAIT, "wdog");
`endif
    step(0, 1, 1, ST_OFF, "wdog_clr");

    // Asynchronous reset while ON.
    step(1, 1, 1, ST_WAIT, "to_on");
    step(1, 1, 1, ST_SETTLE, "to_on");
    from_settle("to_on");
    #2;
    nreset = 1'b0;
    #1;
    check("arst.state", state, 3'd0);
    check("arst.poc",   3'(poc),   3'd1);
    check("arst.io_en", 3'(io_en), 3'd0);
    check("arst.ready", 3'(ready), 3'd0);
    check("arst.fault", 3'(fault), 3'd0);
    #1;
    nreset = 1'b1;
    @(negedge clk);
    step(0, 1, 1, ST_OFF, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
